// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes raw request lines, keeps edge/level pending
// state, masks it, and holds a one-level in-service lock in front of CP0 HWInt.
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             ack,
  output logic [N_SRC-1:0] hwint
);

  typedef enum logic {IDLE = 1'b0, SERVICE = 1'b1} state_t;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_EDGE = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;
  localparam logic [1:0] A_EOI  = 2'd3;

  state_t           state, state_n;
  logic [2:0]       isr_id, isr_id_n;
  logic [N_SRC-1:0] s0, s1, s2;
  logic [N_SRC-1:0] mask, edge_mode, pend, pend_n;
  logic [N_SRC-1:0] rise, clr, elig;
  logic             eoi;

  assign rise = s1 & ~s2;
  assign eoi  = we && (addr == A_EOI);

  // Sources below or equal to the one in service are held off until EOI.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SRC; i++)
      elig[i] = pend[i] & mask[i] & ((state == IDLE) || (i > int'(isr_id)));
  end

  always_comb begin
    clr = '0;
    if (we && (addr == A_PEND))
      clr = wdata[N_SRC-1:0];
    for (int i = 0; i < N_SRC; i++)
      if ((state == SERVICE) && eoi && (int'(isr_id) == i))
        clr[i] = 1'b1;
  end

  // Level bits mirror the synchronized line; edge bits latch, set beats clear.
  always_comb begin
    pend_n = '0;
    for (int i = 0; i < N_SRC; i++)
      if (edge_mode[i])
        pend_n[i] = (pend[i] & ~clr[i]) | rise[i];
      else
        pend_n[i] = s1[i];
  end

  always_comb begin
    state_n  = state;
    isr_id_n = isr_id;
    case (state)
      IDLE: begin
        if (ack && (elig != '0)) begin
          state_n = SERVICE;
          for (int i = 0; i < N_SRC; i++)
            if (elig[i]) isr_id_n = 3'(i);
        end
      end
      SERVICE: begin
        if (eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      isr_id    <= '0;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      mask      <= '0;
      edge_mode <= '0;
      pend      <= '0;
      hwint     <= '0;
    end else begin
      state  <= state_n;
      isr_id <= isr_id_n;
      s0     <= irq_in;
      s1     <= s0;
      s2     <= s1;
      pend   <= pend_n;
      hwint  <= elig;
      if (we && (addr == A_MASK)) mask      <= wdata[N_SRC-1:0];
      if (we && (addr == A_EDGE)) edge_mode <= wdata[N_SRC-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_MASK: rdata[N_SRC-1:0] = mask;
      A_EDGE: rdata[N_SRC-1:0] = edge_mode;
      A_PEND: rdata[N_SRC-1:0] = pend;
      A_EOI: begin
        rdata[31]          = (state == SERVICE);
        rdata[2:0]         = isr_id;
        rdata[8 +: N_SRC]  = s1;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: latency, edge/level pending, priority lock,
// simultaneous events and reset during service.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic [5:0]  hwint;

  int n_cmp = 0;
  int n_bad = 0;

  irq_ctrl #(.N_SRC(6)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .hwint(hwint)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // One-cycle pulse on irq_in, then wait until it is visible on hwint.
  task automatic pulse_src(input logic [5:0] v);
    irq_in = v;
    tick();
    irq_in = '0;
    tick(3);
  endtask

  initial begin
    int hi_cnt;
    reset = 1'b1; irq_in = 6'h3F; we = 1'b0; addr = '0; wdata = '0; ack = 1'b0;

    // Reset with all lines high
    tick(10);
    rd_check("rst_mask", 2'd0, 32'h0);
    rd_check("rst_edge", 2'd1, 32'h0);
    rd_check("rst_pend", 2'd2, 32'h0);
    rd_check("rst_status", 2'd3, 32'h0);
    check("rst_hwint", {26'h0, hwint}, 32'h0);

    reset = 1'b0;
    tick(2);
    rd_check("sync_status", 2'd3, 32'h0000_3F00);
    tick();
    rd_check("level_pend_unmasked", 2'd2, 32'h3F);
    tick();
    check("mask0_hwint", {26'h0, hwint}, 32'h0);
    irq_in = '0;
    tick(4);
    rd_check("level_pend_drop", 2'd2, 32'h0);

    // Edge latency
    wr(2'd1, 32'h3F);
    wr(2'd0, 32'h3F);
    irq_in = 6'h04;
    tick();                // edge N
    irq_in = '0;
    tick();                // N+1
    rd_check("edge_pend_n1", 2'd2, 32'h0);
    tick();                // N+2
    rd_check("edge_pend_n2", 2'd2, 32'h04);
    check("edge_hwint_n2", {26'h0, hwint}, 32'h0);
    tick();                // N+3
    check("edge_hwint_n3", {26'h0, hwint}, 32'h04);
    tick(3);
    check("edge_hwint_held", {26'h0, hwint}, 32'h04);
    wr(2'd2, 32'h04);
    check("w1c_hwint_e1", {26'h0, hwint}, 32'h04);
    tick();
    check("w1c_hwint_e2", {26'h0, hwint}, 32'h0);

    // Level mode, 5-cycle request on source 0
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h01);
    hi_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      irq_in = (k < 5) ? 6'h01 : 6'h00;
      tick();
      if (hwint[0]) hi_cnt++;
      check($sformatf("level_hwint_k%0d", k), {31'h0, hwint[0]},
            {31'h0, (k >= 3 && k <= 7)});
    end
    check("level_hi_cnt", hi_cnt, 32'd5);

    // Priority lock
    wr(2'd1, 32'h3F);
    wr(2'd0, 32'h3F);
    pulse_src(6'h12);
    check("lock_pre_hwint", {26'h0, hwint}, 32'h12);
    pulse_ack();           // edge M
    rd_check("lock_status", 2'd3, 32'h8000_0004);
    check("lock_hwint_m", {26'h0, hwint}, 32'h12);
    tick();
    check("lock_hwint_m1", {26'h0, hwint}, 32'h0);
    pulse_src(6'h20);
    check("lock_higher", {26'h0, hwint}, 32'h20);
    pulse_ack();
    rd_check("nested_ack_ignored", 2'd3, 32'h8000_0004);
    wr(2'd3, 32'hDEAD_BEEF);
    rd_check("eoi_status", 2'd3, 32'h0000_0004);
    rd_check("eoi_pend", 2'd2, 32'h22);
    tick();
    check("eoi_hwint", {26'h0, hwint}, 32'h22);

    // W1C concurrent with a rise: set wins
    irq_in = 6'h08;
    tick(2);
    wr(2'd2, 32'h08);
    irq_in = '0;
    rd_check("w1c_vs_rise", 2'd2, 32'h2A);
    wr(2'd2, 32'h08);
    rd_check("w1c_alone", 2'd2, 32'h22);
    wr(2'd2, 32'h3F);
    rd_check("w1c_all", 2'd2, 32'h0);
    tick();
    pulse_ack();
    rd_check("ack_no_elig", 2'd3, 32'h0000_0004);
    wr(2'd3, 32'h0);
    rd_check("eoi_in_idle", 2'd3, 32'h0000_0004);

    // ack and EOI together while in service
    pulse_src(6'h02);
    pulse_ack();
    rd_check("svc_src1", 2'd3, 32'h8000_0001);
    ack = 1'b1;
    wr(2'd3, 32'h0);
    ack = 1'b0;
    rd_check("ack_eoi_status", 2'd3, 32'h0000_0001);
    rd_check("ack_eoi_pend", 2'd2, 32'h0);

    // Reset during service
    pulse_src(6'h10);
    pulse_ack();
    rd_check("svc_src4", 2'd3, 32'h8000_0004);
    rd_check("svc_pend", 2'd2, 32'h10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_check("midrst_status", 2'd3, 32'h0);
    rd_check("midrst_pend", 2'd2, 32'h0);
    rd_check("midrst_mask", 2'd0, 32'h0);
    check("midrst_hwint", {26'h0, hwint}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
